// File: rtl/hkspi_responder_if.sv
// Register-bank side of the housekeeping SPI responder.
//   reg_addr   : register address (8-bit address byte, zero-extended)
//   reg_wdata  : write data, valid while reg_we is high
//   reg_we     : one-cycle write strobe
//   reg_re     : one-cycle read strobe
//   reg_rdata  : read data, must be valid on the clock after reg_re
// master = responder, slave = register bank.
interface hkspi_responder_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata;

  modport master (
    output reg_addr,
    output reg_wdata,
    output reg_we,
    output reg_re,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr,
    input  reg_wdata,
    input  reg_we,
    input  reg_re,
    output reg_rdata
  );
endinterface

// File: rtl/hkspi_responder.sv
// Housekeeping SPI responder (mode 0, MSB first). Oversamples the SPI pins in
// the core clock domain, decodes command / address / data bytes and issues
// single-cycle read and write strobes to an external register bank.
//
// Ports:
//   clock, reset : core clock, synchronous active-high reset
//   sck, csb, sdi: SPI pins (asynchronous to clock)
//   sdo, sdo_enb : SPI data out and its active-low output enable
//   busy         : high while synchronized csb is low
//   bus          : register bank interface (master side)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | csb high, or waiting for csb to be seen high after reset
// CMD    | shifting in the command byte
// ADDR   | shifting in the address byte
// DATA   | streaming data bytes (read and/or write)
// IGNORE | rest of transaction discarded until csb high
module hkspi_responder #(
  parameter int ADDR_W = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic sck,
  input  logic csb,
  input  logic sdi,
  output logic sdo,
  output logic sdo_enb,
  output logic busy,
  hkspi_responder_if.master bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_IGNORE = 3'd4;

  // pin synchronizers; sck_s3 is the previous synchronized sck for edge detect
  logic sck_s1, sck_s2, sck_s3;
  logic csb_s1, csb_s2;
  logic sdi_s1, sdi_s2;

  always_ff @(posedge clock) begin
    if (reset) begin
      sck_s1 <= 1'b0;
      sck_s2 <= 1'b0;
      sck_s3 <= 1'b0;
      csb_s1 <= 1'b1;
      csb_s2 <= 1'b1;
      sdi_s1 <= 1'b0;
      sdi_s2 <= 1'b0;
    end else begin
      sck_s1 <= sck;
      sck_s2 <= sck_s1;
      sck_s3 <= sck_s2;
      csb_s1 <= csb;
      csb_s2 <= csb_s1;
      sdi_s1 <= sdi;
      sdi_s2 <= sdi_s1;
    end
  end

  logic sck_rise, sck_fall;
  assign sck_rise = sck_s2 & ~sck_s3;
  assign sck_fall = ~sck_s2 & sck_s3;
  assign busy     = ~csb_s2;

  logic [2:0] state;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sh;
  logic [7:0] byte_next;
  logic       is_wr, is_rd, stream;
  logic [2:0] byte_left;
  logic       last_byte;
  logic [1:0] settle;
  logic       armed;
  logic [7:0] tx_sh;
  logic       out_en, out_bit;
  logic       inc_pend, re_pend;

  assign byte_next = {rx_sh, sdi_s2};
  assign last_byte = ~stream && (byte_left == 3'd1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      bit_cnt       <= 3'd0;
      rx_sh         <= 7'd0;
      is_wr         <= 1'b0;
      is_rd         <= 1'b0;
      stream        <= 1'b0;
      byte_left     <= 3'd0;
      // synchronizer flops hold reset values for two clocks; wait them out
      // before trusting csb_s2 to arm a new transaction
      settle        <= 2'd2;
      armed         <= 1'b0;
      tx_sh         <= 8'd0;
      out_en        <= 1'b0;
      out_bit       <= 1'b0;
      inc_pend      <= 1'b0;
      re_pend       <= 1'b0;
      sdo           <= 1'b0;
      sdo_enb       <= 1'b1;
      bus.reg_addr  <= '0;
      bus.reg_wdata <= 8'd0;
      bus.reg_we    <= 1'b0;
      bus.reg_re    <= 1'b0;
    end else begin
      bus.reg_we <= 1'b0;
      bus.reg_re <= 1'b0;
      inc_pend   <= 1'b0;
      re_pend    <= 1'b0;

      // output stage adds one clock after the fall is processed
      sdo     <= out_en & out_bit;
      sdo_enb <= ~out_en;

      if (settle != 2'd0)
        settle <= settle - 2'd1;
      else if (csb_s2)
        armed <= 1'b1;

      // write-side follow-up: bump address, then prefetch for read/write
      if (inc_pend)
        bus.reg_addr <= bus.reg_addr + ADDR_W'(1);
      if (re_pend)
        bus.reg_re <= 1'b1;

      if (csb_s2) begin
        state   <= ST_IDLE;
        bit_cnt <= 3'd0;
        out_en  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            bit_cnt <= 3'd0;
            if (armed)
              state <= ST_CMD;
          end

          ST_CMD: begin
            if (sck_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              rx_sh   <= byte_next[6:0];
              if (bit_cnt == 3'd7) begin
                is_wr     <= byte_next[7];
                is_rd     <= byte_next[6];
                byte_left <= byte_next[5:3];
                stream    <= (byte_next[5:3] == 3'd0);
                state     <= (byte_next[7:6] == 2'b00) ? ST_IGNORE : ST_ADDR;
              end
            end
          end

          ST_ADDR: begin
            if (sck_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              rx_sh   <= byte_next[6:0];
              if (bit_cnt == 3'd7) begin
                bus.reg_addr <= ADDR_W'(byte_next);
                bus.reg_re   <= is_rd;
                state        <= ST_DATA;
              end
            end
          end

          ST_DATA: begin
            if (sck_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              rx_sh   <= byte_next[6:0];
              if (bit_cnt == 3'd7) begin
                if (!stream)
                  byte_left <= byte_left - 3'd1;
                if (is_wr) begin
                  bus.reg_we    <= 1'b1;
                  bus.reg_wdata <= byte_next;
                  inc_pend      <= 1'b1;
                  // read/write: prefetch next address only after the write
                  re_pend       <= is_rd & ~last_byte;
                end else begin
                  bus.reg_addr <= bus.reg_addr + ADDR_W'(1);
                  bus.reg_re   <= ~last_byte;
                end
                if (last_byte) begin
                  state  <= ST_IGNORE;
                  out_en <= 1'b0;
                end
              end
            end else if (sck_fall && is_rd) begin
              out_en  <= 1'b1;
              out_bit <= tx_sh[7];
              tx_sh   <= {tx_sh[6:0], 1'b0};
            end
          end

          ST_IGNORE: begin
            out_en <= 1'b0;
          end

          default: state <= ST_IDLE;
        endcase
      end

      // read data arrives the clock after the strobe; a load wins over a shift
      if (bus.reg_re)
        tx_sh <= bus.reg_rdata;
    end
  end

endmodule

// File: tb/tb_hkspi_responder.sv
`timescale 1ns/1ps
module tb_hkspi_responder;

  localparam int HALF = 8;  // SCK half period in core clocks

  logic clock = 1'b0;
  logic reset;
  logic sck, csb, sdi;
  logic sdo, sdo_enb, busy;
  logic bank_init;

  always #5 clock = ~clock;

  hkspi_responder_if #(.ADDR_W(8)) bus ();

  hkspi_responder #(.ADDR_W(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .sck     (sck),
    .csb     (csb),
    .sdi     (sdi),
    .sdo     (sdo),
    .sdo_enb (sdo_enb),
    .busy    (busy),
    .bus     (bus.master)
  );

  // ---------------- register bank ----------------
  logic [7:0] mem [256];

  function automatic logic [7:0] bank_seed(input int i);
    case (i)
      0: return 8'h00;
      1: return 8'h04;
      2: return 8'h56;
      3: return 8'h10;
      default: return 8'(i * 29 + 90);
    endcase
  endfunction

  always @(posedge clock) begin
    if (bank_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= bank_seed(i);
    end else if (bus.reg_we) begin
      mem[bus.reg_addr] <= bus.reg_wdata;
    end
  end

  assign bus.reg_rdata = mem[bus.reg_addr];

  // ---------------- monitor ----------------
  logic [16:0] obs_q[$];
  int overlap_cnt = 0;
  int enb_low_cnt = 0;

  always @(negedge clock) begin
    if (bus.reg_we) obs_q.push_back({1'b1, bus.reg_addr, bus.reg_wdata});
    if (bus.reg_re) obs_q.push_back({1'b0, bus.reg_addr, 8'h00});
    if (bus.reg_we && bus.reg_re) overlap_cnt++;
    if (!sdo_enb) enb_low_cnt++;
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [7:0] ref_mem [256];
  logic [7:0] model_addr;

  // ---------------- SPI host ----------------
  task automatic spi_bits(input logic [7:0] tx, input int nbits,
                          output logic [7:0] rx, output logic enb7);
    rx = 8'h00;
    enb7 = 1'b1;
    for (int b = 7; b > 7 - nbits; b--) begin
      sdi = tx[b];
      repeat (HALF) @(negedge clock);
      rx[b] = sdo;
      if (b == 7) enb7 = sdo_enb;
      sck = 1'b1;
      repeat (HALF) @(negedge clock);
      sck = 1'b0;
    end
  endtask

  task automatic run_txn(input string name, input logic [7:0] cmd, input logic [7:0] addr,
                         input logic [7:0] wq[$]);
    logic [16:0] exp_ev[$];
    logic [7:0]  exp_rx[$];
    logic        exp_en[$];
    logic [7:0]  got_rx[$];
    logic        got_en[$];
    logic [7:0]  rx;
    logic        e7;
    logic        wr, rd, valid;
    int          n, nproc, base, enb_base, got_n;
    logic [7:0]  a;

    // transaction-level model
    wr = cmd[7];
    rd = cmd[6];
    valid = wr | rd;
    n = int'(cmd[5:3]);
    nproc = (n == 0) ? wq.size() : ((n < wq.size()) ? n : wq.size());
    if (!valid) nproc = 0;
    a = addr;
    if (valid && rd) exp_ev.push_back({1'b0, a, 8'h00});
    for (int i = 0; i < wq.size(); i++) begin
      if (i < nproc) begin
        exp_rx.push_back(rd ? ref_mem[a] : 8'h00);
        exp_en.push_back(!rd);
        if (wr) begin
          exp_ev.push_back({1'b1, a, wq[i]});
          ref_mem[a] = wq[i];
        end
        a = a + 8'd1;
        if (rd && (n == 0 || i < n - 1)) exp_ev.push_back({1'b0, a, 8'h00});
      end else begin
        exp_rx.push_back(8'h00);
        exp_en.push_back(1'b1);
      end
    end
    if (valid) model_addr = a;

    // drive
    base = obs_q.size();
    enb_base = enb_low_cnt;
    csb = 1'b0;
    repeat (8) @(negedge clock);
    spi_bits(cmd, 8, rx, e7);
    spi_bits(addr, 8, rx, e7);
    for (int i = 0; i < wq.size(); i++) begin
      spi_bits(wq[i], 8, rx, e7);
      got_rx.push_back(rx);
      got_en.push_back(e7);
    end
    repeat (HALF) @(negedge clock);
    csb = 1'b1;
    repeat (12) @(negedge clock);

    // compare
    got_n = obs_q.size() - base;
    check($sformatf("%s n_events", name), got_n, exp_ev.size());
    for (int i = 0; i < exp_ev.size() && i < got_n; i++)
      check($sformatf("%s ev%0d", name, i), obs_q[base + i], exp_ev[i]);
    for (int i = 0; i < wq.size(); i++) begin
      check($sformatf("%s rx%0d", name, i), got_rx[i], exp_rx[i]);
      check($sformatf("%s enb%0d", name, i), got_en[i], exp_en[i]);
    end
    check($sformatf("%s enb_low_seen", name), (enb_low_cnt != enb_base), valid && rd);
    check($sformatf("%s reg_addr", name), bus.reg_addr, model_addr);
    check($sformatf("%s sdo_enb_idle", name), sdo_enb, 1'b1);
  endtask

  task automatic check_reset_outputs(input string name);
    check($sformatf("%s sdo", name), sdo, 1'b0);
    check($sformatf("%s sdo_enb", name), sdo_enb, 1'b1);
    check($sformatf("%s reg_we", name), bus.reg_we, 1'b0);
    check($sformatf("%s reg_re", name), bus.reg_re, 1'b0);
    check($sformatf("%s reg_addr", name), bus.reg_addr, 8'h00);
    check($sformatf("%s reg_wdata", name), bus.reg_wdata, 8'h00);
    check($sformatf("%s busy", name), busy, 1'b0);
  endtask

  initial begin
    #800us;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] wq[$];
    logic [7:0] rx;
    logic       e7;
    logic [7:0] cmd, addr;
    int         base;

    reset = 1'b1;
    bank_init = 1'b1;
    csb = 1'b1;
    sck = 1'b0;
    sdi = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = bank_seed(i);
    model_addr = 8'h00;
    repeat (4) @(negedge clock);
    bank_init = 1'b0;
    check_reset_outputs("por");
    reset = 1'b0;
    repeat (6) @(negedge clock);

    // read one byte at 0x03
    wq = '{8'h00};
    run_txn("rd03", 8'h40, 8'h03, wq);

    // two writes to 0x07
    wq = '{8'h01};
    run_txn("wr07a", 8'h80, 8'h07, wq);
    wq = '{8'h00};
    run_txn("wr07b", 8'h80, 8'h07, wq);

    // long read stream from 0x00
    wq.delete();
    for (int i = 0; i < 19; i++) wq.push_back(8'h00);
    run_txn("rdstream", 8'h40, 8'h00, wq);

    // one-byte read at 0xFF, two bytes clocked
    wq = '{8'h00, 8'h00};
    run_txn("rd1_ff", 8'h48, 8'hFF, wq);

    // write stream and read/write stream across the wrap
    wq = '{8'hA1, 8'hB2, 8'hC3};
    run_txn("wr_wrap", 8'h80, 8'hFF, wq);
    wq = '{8'h3C, 8'h4D, 8'h5E};
    run_txn("rw_wrap", 8'hC0, 8'hFE, wq);

    // abort after 5 bits of a write data byte
    base = obs_q.size();
    csb = 1'b0;
    repeat (8) @(negedge clock);
    spi_bits(8'h80, 8, rx, e7);
    spi_bits(8'h30, 8, rx, e7);
    spi_bits(8'hFF, 5, rx, e7);
    repeat (HALF) @(negedge clock);
    csb = 1'b1;
    repeat (12) @(negedge clock);
    model_addr = 8'h30;
    check("abort n_events", obs_q.size() - base, 0);
    check("abort reg_addr", bus.reg_addr, model_addr);
    wq = '{8'h11, 8'h22, 8'h33};
    run_txn("after_abort", 8'hC0, 8'h30, wq);

    // reset in the middle of the address byte
    csb = 1'b0;
    repeat (8) @(negedge clock);
    spi_bits(8'h80, 8, rx, e7);
    spi_bits(8'h55, 4, rx, e7);
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("midaddr_rst");
    reset = 1'b0;
    model_addr = 8'h00;
    // csb still low: the responder must not decode anything
    base = obs_q.size();
    repeat (8) @(negedge clock);
    check("post_rst busy", busy, 1'b1);
    spi_bits(8'h80, 8, rx, e7);
    spi_bits(8'h22, 8, rx, e7);
    spi_bits(8'h33, 8, rx, e7);
    repeat (HALF) @(negedge clock);
    csb = 1'b1;
    repeat (12) @(negedge clock);
    check("post_rst n_events", obs_q.size() - base, 0);
    check("post_rst reg_addr", bus.reg_addr, model_addr);
    wq = '{8'h9A, 8'h00};
    run_txn("after_rst", 8'hD0, 8'h40, wq);

    // randomized transactions
    for (int t = 0; t < 20; t++) begin
      cmd  = {2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom)};
      addr = ($urandom_range(0, 4) == 0) ? 8'hFE : 8'($urandom);
      wq.delete();
      for (int i = 0; i < int'($urandom_range(0, 5)); i++) wq.push_back(8'($urandom));
      run_txn($sformatf("rnd%0d_c%02h", t, cmd), cmd, addr, wq);
    end

    check("we_re_overlap", overlap_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
